multicycle_control: RTL

- Main control FSM for a multicycle build of the team's MIPS-subset CPU. It sequences one shared memory, one ALU and the IR/MDR/A/B/ALUOut registers across 3–5 states per instruction.
- ISA covered: add, slt (R-type), addi, lw, sw, beq, j.
- Adds a memory wait handshake (mem_ready) so slow memories no longer force a long clock period.
- Sits between the instruction register opcode field and the datapath mux/enable pins.

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/mc_ctrl_outdec.sv | 82 ++++++++
 rtl/multicycle_control.sv | 104 ++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control FSM: state
// encodings, opcode constants, datapath mux codes and the bundled control
// word passed from the output decoder to the top level.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  localparam int OPC_W   = 6;
  localparam int STATE_W = 4;

  // Encodings are visible on state_dbg, so the values are fixed explicitly.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTEXEC   = 4'd6,
    S_RTWB     = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// -----------------------------------------------------------------------------
// mc_ctrl_outdec
// Combinational map from the current FSM state (plus mem_ready for the Mealy
// gated fetch strobes) to the full datapath control word.
//   state     : current FSM state
//   mem_ready : memory access completes this cycle
//   ctrl      : control word (mux selects, enables, strobes, halted)
// -----------------------------------------------------------------------------
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: defaulting the whole word first keeps every field driven on every
    // path, so no latch is inferred and unlisted outputs read as 0.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle the instruction word is valid.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle MIPS-subset CPU (add, slt, addi, lw, sw,
// beq, j). Holds the state register and next-state logic; control outputs
// come from mc_ctrl_outdec and are forced to 0 while rst is high.
//   clk, rst          : clock, asynchronous active-high reset
//   opcode            : IR[31:26], decoded in DECODE/MEMADR
//   mem_ready         : memory access completes this cycle
//   PCWrite..PCSource : datapath enables and mux selects
//   halted            : illegal opcode seen, held until reset
//   state_dbg         : current state encoding
// -----------------------------------------------------------------------------
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W   = mc_ctrl_pkg::OPC_W,
  parameter int STATE_W = mc_ctrl_pkg::STATE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               halted,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;

  // NOTE: state is sequential, so it is only ever updated with <=.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTEXEC;
            OP_BEQ:       state <= S_BEQ;
            OP_ADDI:      state <= S_ADDIEXEC;
            OP_J:         state <= S_JUMP;
            default:      state <= S_HALT;
          endcase
        end
        // IR still holds the same instruction, so opcode is stable here.
        S_MEMADR:   state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWR:    if (mem_ready) state <= S_FETCH;
        S_RTEXEC:   state <= S_RTWB;
        S_RTWB:     state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_ADDIEXEC: state <= S_ADDIWB;
        S_ADDIWB:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_HALT;
      endcase
    end
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // Gate with rst so a reset in mid-access drops every strobe in the same
  // timestep, not at the next clock edge.
  assign ctrl = rst ? '0 : dec;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign halted      = ctrl.halted;
  assign state_dbg   = STATE_W'(state);

endmodule
